// File: rtl/mouse_position_tracker.sv
// PS/2 mouse packet parser: integrates signed deltas into clamped X/Y cursor positions.
// Optional macro MOUSE_TRACKER_TIMEOUT_EN drops stalled partial packets after TIMEOUT_CYCLES.
module mouse_position_tracker #(
  parameter int X_MAX  = 639,
  parameter int Y_MAX  = 479,
  parameter int X_INIT = 320,
  parameter int Y_INIT = 240
`ifdef MOUSE_TRACKER_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 2000000
`endif
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic [9:0] MOUSE_X_POS,
  output logic [9:0] MOUSE_Y_POS,
  output logic       MOUSE_LEFT,
  output logic       MOUSE_RIGHT,
  output logic       MOUSE_MIDDLE,
  output logic       pos_update
);

  // state   | meaning
  // WAIT_B0 | idle, waiting for a byte with the sync bit set
  // WAIT_B1 | byte0 held, waiting for X delta
  // WAIT_B2 | byte0/1 held, waiting for Y delta
  // APPLY   | one cycle: outputs take the new packet, rx byte treated as byte0
  typedef enum logic [1:0] {WAIT_B0, WAIT_B1, WAIT_B2, APPLY} state_t;

  state_t     state, state_nxt;
  logic [7:0] b0, b1, b2;
  logic       ld_b0, ld_b1, ld_b2;
  logic       take_b0;
  logic       timeout;

`ifdef MOUSE_TRACKER_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] gap_cnt;
  logic             in_packet;

  assign in_packet = (state == WAIT_B1) || (state == WAIT_B2);
  // Fires on the cycle whose edge would bring the gap count to TIMEOUT_CYCLES.
  assign timeout   = in_packet && (gap_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (!rst_n)                            gap_cnt <= '0;
    else if (rx_valid || !in_packet || timeout) gap_cnt <= '0;
    else                                   gap_cnt <= gap_cnt + 1'b1;
  end
`else
  assign timeout = 1'b0;
`endif

  assign take_b0 = rx_valid && rx_data[3];

  always_ff @(posedge clk) begin
    if (!rst_n) state <= WAIT_B0;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    ld_b0     = 1'b0;
    ld_b1     = 1'b0;
    ld_b2     = 1'b0;
    case (state)
      WAIT_B0, APPLY: begin
        ld_b0     = take_b0;
        state_nxt = take_b0 ? WAIT_B1 : WAIT_B0;
      end
      WAIT_B1: begin
        if (timeout) begin
          ld_b0     = take_b0;
          state_nxt = take_b0 ? WAIT_B1 : WAIT_B0;
        end else if (rx_valid) begin
          ld_b1     = 1'b1;
          state_nxt = WAIT_B2;
        end
      end
      WAIT_B2: begin
        if (timeout) begin
          ld_b0     = take_b0;
          state_nxt = take_b0 ? WAIT_B1 : WAIT_B0;
        end else if (rx_valid) begin
          ld_b2     = 1'b1;
          state_nxt = APPLY;
        end
      end
      default: state_nxt = WAIT_B0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      b0 <= '0;
      b1 <= '0;
      b2 <= '0;
    end else begin
      if (ld_b0) b0 <= rx_data;
      if (ld_b1) b1 <= rx_data;
      if (ld_b2) b2 <= rx_data;
    end
  end

  logic signed [11:0] dx, dy, x_sum, y_sum;

  assign dx    = b0[6] ? 12'sd0 : signed'({{4{b0[4]}}, b1});
  assign dy    = b0[7] ? 12'sd0 : signed'({{4{b0[5]}}, b2});
  // PS/2 positive Y is up, screen Y grows downward.
  assign x_sum = signed'({2'b00, MOUSE_X_POS}) + dx;
  assign y_sum = signed'({2'b00, MOUSE_Y_POS}) - dy;

  function automatic logic [9:0] clamp(input logic signed [11:0] v, input logic [9:0] hi);
    if (v < 12'sd0)                       return '0;
    else if (v > signed'({2'b00, hi}))    return hi;
    else                                  return v[9:0];
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      MOUSE_X_POS  <= 10'(X_INIT);
      MOUSE_Y_POS  <= 10'(Y_INIT);
      MOUSE_LEFT   <= 1'b0;
      MOUSE_RIGHT  <= 1'b0;
      MOUSE_MIDDLE <= 1'b0;
      pos_update   <= 1'b0;
    end else begin
      pos_update <= (state == APPLY);
      if (state == APPLY) begin
        MOUSE_X_POS  <= clamp(x_sum, 10'(X_MAX));
        MOUSE_Y_POS  <= clamp(y_sum, 10'(Y_MAX));
        MOUSE_LEFT   <= b0[0];
        MOUSE_RIGHT  <= b0[1];
        MOUSE_MIDDLE <= b0[2];
      end
    end
  end

endmodule
